mc_rsp_responder: RTL and testbench

Memory-controller responder for the personality MC request/response interface. It accepts the 8-byte load and store requests issued by a personality unit and services them from an internal 64-bit word memory. It returns load data in order, with a fixed pipeline latency, on the response channel. It drives the read/write request stalls and honours the personality's response stall. It is the behavioural/synthesizable far end used to exercise personality units in block-level simulation and in loopback builds.

---
 rtl/mc_rsp_responder.sv | 189 ++++++++++++++++++
 tb/tb_mc_rsp_responder.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_rsp_responder.sv
// mc_rsp_responder: far-end memory-controller model for a personality unit.
// Services 8-byte loads and stores from an internal 64-bit word memory and
// returns load data in request order, RD_LAT cycles after the request when
// the response queue is empty and not stalled.
module mc_rsp_responder #(
    parameter int ADDR_BITS  = 10,
    parameter int RD_LAT     = 4,
    parameter int RSPQ_DEPTH = 16,
    parameter int RSPQ_AFULL = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mc_req_ld,
    input  logic        mc_req_st,
    input  logic [47:0] mc_req_vadr,
    input  logic [1:0]  mc_req_size,
    input  logic        mc_req_flush,
    input  logic [63:0] mc_req_wrd_rdctl,
    output logic        mc_rd_rq_stall,
    output logic        mc_wr_rq_stall,
    output logic        mc_rsp_push,
    output logic [31:0] mc_rsp_rdctl,
    output logic [63:0] mc_rsp_data,
    input  logic        mc_rsp_stall,
    input  logic        cfg_wr_stall,
    output logic [31:0] ld_cnt,
    output logic [31:0] st_cnt,
    output logic        err_ovf,
    output logic        err_proto
);

    // The read itself is the first of RD_LAT cycles; the remaining stages
    // carry the read result before it lands in the response FIFO.
    localparam int STAGES = RD_LAT - 1;
    localparam int CNT_W  = $clog2(RSPQ_DEPTH + 1);
    localparam int PTR_W  = (RSPQ_DEPTH > 1) ? $clog2(RSPQ_DEPTH) : 1;
    localparam int WORDS  = 1 << ADDR_BITS;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSPQ_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(RSPQ_AFULL);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSPQ_DEPTH - 1);

    typedef struct packed {
        logic [31:0] rdctl;
        logic [63:0] data;
    } rsp_t;

    logic [63:0]          mem [WORDS];
    logic [ADDR_BITS-1:0] idx;
    logic                 proto_bad;
    logic                 ld_acc;
    logic                 ld_drop;
    logic                 fifo_empty;
    logic                 rsp_pop;
    logic                 fifo_wr;
    logic [CNT_W-1:0]     out_cnt;
    logic [CNT_W-1:0]     out_cnt_nxt;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [STAGES-1:0]    vld_p;
    rsp_t                 ent_p [STAGES];
    rsp_t                 fifo_mem [RSPQ_DEPTH];
    rsp_t                 head;
    logic                 unused_bits;

    // Upper address bits wrap away and flush has no meaning for this model.
    assign unused_bits = ^{mc_req_flush, mc_req_vadr[47:ADDR_BITS+3]};

    // Misaligned addresses are aligned down by simply dropping vadr[2:0].
    assign idx = mc_req_vadr[ADDR_BITS+2:3];

    assign proto_bad = ((mc_req_ld || mc_req_st) &&
                        ((mc_req_size != 2'h3) || (mc_req_vadr[2:0] != 3'h0))) ||
                       (mc_req_ld && mc_req_st);

    // A load is only refused when every response slot is already spoken for.
    assign ld_acc  = mc_req_ld && (out_cnt != DEPTH_C);
    assign ld_drop = mc_req_ld && (out_cnt == DEPTH_C);

    assign fifo_empty  = (fifo_cnt == '0);
    assign rsp_pop     = !fifo_empty && !mc_rsp_stall;
    assign fifo_wr     = vld_p[STAGES-1];
    assign head        = fifo_mem[rd_ptr];
    assign mc_rsp_push = rsp_pop;

    // Outputs read as zero whenever there is nothing valid at the queue head.
    assign mc_rsp_rdctl = fifo_empty ? '0 : head.rdctl;
    assign mc_rsp_data  = fifo_empty ? '0 : head.data;

    // Next outstanding-load count: +1 per accepted load, -1 per push.
    always_comb begin
        out_cnt_nxt = out_cnt;
        if (ld_acc && !rsp_pop) begin
            out_cnt_nxt = out_cnt + ONE_C;
        end else if (!ld_acc && rsp_pop) begin
            out_cnt_nxt = out_cnt - ONE_C;
        end
    end

    // Memory write/read and load-data pipeline; the read sees pre-store data.
    always_ff @(posedge clk) begin
        if (mc_req_st) begin
            mem[idx] <= mc_req_wrd_rdctl;
        end
        ent_p[0] <= {mc_req_wrd_rdctl[31:0], mem[idx]};
        for (int s = 1; s < STAGES; s++) begin
            ent_p[s] <= ent_p[s-1];
        end
    end

    // Response FIFO storage, written from the last pipeline stage.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= ent_p[STAGES-1];
        end
    end

    // Load valid pipeline and outstanding-load count; reset drops in-flight loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p   <= '0;
            out_cnt <= '0;
        end else begin
            vld_p[0] <= ld_acc;
            for (int s = 1; s < STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
            out_cnt <= out_cnt_nxt;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rsp_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (fifo_wr && !rsp_pop) begin
                fifo_cnt <= fifo_cnt + ONE_C;
            end else if (!fifo_wr && rsp_pop) begin
                fifo_cnt <= fifo_cnt - ONE_C;
            end
        end
    end

    // Registered request stalls, one cycle behind the count / cfg change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_rd_rq_stall <= 1'b0;
            mc_wr_rq_stall <= 1'b0;
        end else begin
            mc_rd_rq_stall <= (out_cnt_nxt >= AFULL_C);
            mc_wr_rq_stall <= cfg_wr_stall;
        end
    end

    // Request counters (wrap at 2^32) and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt    <= '0;
            st_cnt    <= '0;
            err_ovf   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (ld_acc) begin
                ld_cnt <= ld_cnt + 32'd1;
            end
            if (mc_req_st) begin
                st_cnt <= st_cnt + 32'd1;
            end
            if (ld_drop) begin
                err_ovf <= 1'b1;
            end
            if (proto_bad) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_rsp_responder.sv
// Bench for mc_rsp_responder: directed scenarios plus a randomized run, all
// checked against a transaction-level model (word array + response queue).
module tb_mc_rsp_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mc_req_ld = 1'b0;
    logic        mc_req_st = 1'b0;
    logic [47:0] mc_req_vadr = '0;
    logic [1:0]  mc_req_size = 2'h3;
    logic        mc_req_flush = 1'b0;
    logic [63:0] mc_req_wrd_rdctl = '0;
    logic        mc_rd_rq_stall;
    logic        mc_wr_rq_stall;
    logic        mc_rsp_push;
    logic [31:0] mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_stall = 1'b0;
    logic        cfg_wr_stall = 1'b0;
    logic [31:0] ld_cnt;
    logic [31:0] st_cnt;
    logic        err_ovf;
    logic        err_proto;

    mc_rsp_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mc_req_ld        (mc_req_ld),
        .mc_req_st        (mc_req_st),
        .mc_req_vadr      (mc_req_vadr),
        .mc_req_size      (mc_req_size),
        .mc_req_flush     (mc_req_flush),
        .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
        .mc_rd_rq_stall   (mc_rd_rq_stall),
        .mc_wr_rq_stall   (mc_wr_rq_stall),
        .mc_rsp_push      (mc_rsp_push),
        .mc_rsp_rdctl     (mc_rsp_rdctl),
        .mc_rsp_data      (mc_rsp_data),
        .mc_rsp_stall     (mc_rsp_stall),
        .cfg_wr_stall     (cfg_wr_stall),
        .ld_cnt           (ld_cnt),
        .st_cnt           (st_cnt),
        .err_ovf          (err_ovf),
        .err_proto        (err_proto)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdctl;
        logic [63:0] data;
    } rsp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    rsp_t        exp_q[$];
    rsp_t        rcv_q[$];
    int          rcv_cyc[$];
    logic [63:0] mdl_mem [1024];
    logic [31:0] mdl_ld = 0;
    logic [31:0] mdl_st = 0;
    logic        mdl_ovf = 1'b0;
    logic        mdl_proto = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every response seen, with the cycle it appeared in.
    always @(negedge clk) begin
        if (mc_rsp_push) begin
            rcv_q.push_back({mc_rsp_rdctl, mc_rsp_data});
            rcv_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        rcv_q.delete();
        rcv_cyc.delete();
    endtask

    // Present one request for one cycle and apply it to the model.
    task automatic drive_req(input logic ld, input logic st, input logic [47:0] vadr,
                             input logic [1:0] size, input logic [63:0] wrd);
        int idx;
        idx = int'(vadr[12:3]);
        if (((ld || st) && (size != 2'h3 || vadr[2:0] != 3'h0)) || (ld && st))
            mdl_proto = 1'b1;
        if (ld) begin
            if (exp_q.size() - rcv_q.size() < 16) begin
                exp_q.push_back({wrd[31:0], mdl_mem[idx]});
                mdl_ld = mdl_ld + 1;
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        if (st) begin
            mdl_mem[idx] = wrd;
            mdl_st = mdl_st + 1;
        end
        mc_req_ld = ld;
        mc_req_st = st;
        mc_req_vadr = vadr;
        mc_req_size = size;
        mc_req_wrd_rdctl = wrd;
        cycle();
        mc_req_ld = 1'b0;
        mc_req_st = 1'b0;
        mc_req_size = 2'h3;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && rcv_q.size() < exp_q.size(); k++) cycle();
        repeat (8) cycle();
    endtask

    task automatic test_reset();
        mc_req_ld = 1'b1;
        cfg_wr_stall = 1'b1;
        repeat (3) cycle();
        n_vec++;
        if ({mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push, mc_rsp_rdctl, mc_rsp_data,
             ld_cnt, st_cnt, err_ovf, err_proto} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rsp_push=%b wr_stall=%b ld_cnt=%0d want all zero",
                     mc_rsp_push, mc_wr_rq_stall, ld_cnt);
        end
        mc_req_ld = 1'b0;
        cfg_wr_stall = 1'b0;
        cycle();
        reset = 1'b0;
        repeat (2) cycle();
        clear_q();
        n_vec++;
        if ({mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push, ld_cnt, st_cnt, err_ovf, err_proto} !== '0) begin
            n_err++;
            $display("FAIL post_reset_idle: got ld_cnt=%0d st_cnt=%0d push=%b want zero",
                     ld_cnt, st_cnt, mc_rsp_push);
        end
    endtask

    task automatic test_store_readback();
        int   ld_cyc;
        rsp_t got;
        drive_req(1'b0, 1'b1, 48'h1000, 2'h3, 64'h0123_4567_89AB_CDEF);
        ld_cyc = cyc;
        drive_req(1'b1, 1'b0, 48'h1000, 2'h3, 64'h55);
        wait_drain();
        n_vec++;
        if (rcv_q.size() != 1) begin
            n_err++;
            $display("FAIL readback_count: got %0d want 1", rcv_q.size());
        end
        got = (rcv_q.size() > 0) ? rcv_q[0] : '0;
        n_vec++;
        if (got !== {32'h55, 64'h0123_4567_89AB_CDEF}) begin
            n_err++;
            $display("FAIL readback_rsp: got %h want %h", got, {32'h55, 64'h0123_4567_89AB_CDEF});
        end
        n_vec++;
        if (rcv_cyc.size() == 0 || rcv_cyc[0] != ld_cyc + 4) begin
            n_err++;
            $display("FAIL readback_latency: got cycle %0d want %0d",
                     (rcv_cyc.size() > 0) ? rcv_cyc[0] : -1, ld_cyc + 4);
        end
        n_vec++;
        if (ld_cnt !== 32'd1 || st_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL readback_counts: got ld=%0d st=%0d want ld=1 st=1", ld_cnt, st_cnt);
        end
        clear_q();
    endtask

    task automatic test_wrap();
        rsp_t got;
        drive_req(1'b0, 1'b1, 48'h0, 2'h3, 64'hA5);
        drive_req(1'b1, 1'b0, 48'h2000, 2'h3, 64'h77);
        wait_drain();
        got = (rcv_q.size() > 0) ? rcv_q[0] : '0;
        n_vec++;
        if (rcv_q.size() != 1 || got.data !== 64'hA5) begin
            n_err++;
            $display("FAIL wrap_data: got %h (n=%0d) want 00000000000000a5", got.data, rcv_q.size());
        end
        clear_q();
    endtask

    task automatic test_wr_stall();
        cfg_wr_stall = 1'b1;
        n_vec++;
        if (mc_wr_rq_stall !== 1'b0) begin
            n_err++;
            $display("FAIL wr_stall_delay: got %b want 0", mc_wr_rq_stall);
        end
        cycle();
        n_vec++;
        if (mc_wr_rq_stall !== 1'b1) begin
            n_err++;
            $display("FAIL wr_stall_set: got %b want 1", mc_wr_rq_stall);
        end
        cfg_wr_stall = 1'b0;
        cycle();
        n_vec++;
        if (mc_wr_rq_stall !== 1'b0) begin
            n_err++;
            $display("FAIL wr_stall_clear: got %b want 0", mc_wr_rq_stall);
        end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        first_cyc = cyc;
        for (int i = 0; i < 6; i++)
            drive_req(1'b1, 1'b0, (i % 2 == 0) ? 48'h1000 : 48'h0, 2'h3, 64'(100 + i));
        wait_drain();
        n_vec++;
        if (rcv_q.size() != 6) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 6", rcv_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= rcv_cyc.size() || rcv_cyc[i] != first_cyc + 4 + i ||
                rcv_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_rsp[%0d]: got cycle %0d want cycle %0d", i,
                         (i < rcv_cyc.size()) ? rcv_cyc[i] : -1, first_cyc + 4 + i);
            end
        end
        clear_q();
    endtask

    task automatic test_back_pressure();
        rsp_t got;
        mc_rsp_stall = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            drive_req(1'b1, 1'b0, ($urandom_range(0, 1) == 1) ? 48'h1000 : 48'h0, 2'h3,
                      64'($urandom));
            n_vec++;
            if (mc_rd_rq_stall !== (i >= 12)) begin
                n_err++;
                $display("FAIL bp_rd_stall after load %0d: got %b want %b", i, mc_rd_rq_stall, i >= 12);
            end
        end
        repeat (4) cycle();
        n_vec++;
        if (rcv_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_push_while_stalled: got %0d pushes want 0", rcv_q.size());
        end
        mc_rsp_stall = 1'b0;
        wait_drain();
        n_vec++;
        if (rcv_q.size() != 14) begin
            n_err++;
            $display("FAIL bp_count: got %0d want 14", rcv_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rcv_q.size()) ? rcv_q[i] : '0;
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_rsp[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        n_vec++;
        if (err_ovf !== 1'b0 || mc_rd_rq_stall !== 1'b0) begin
            n_err++;
            $display("FAIL bp_flags: got ovf=%b rd_stall=%b want 0 0", err_ovf, mc_rd_rq_stall);
        end
        clear_q();
    endtask

    task automatic test_overflow();
        rsp_t        got;
        logic [31:0] ld_before;
        ld_before = ld_cnt;
        mc_rsp_stall = 1'b1;
        for (int i = 0; i < 17; i++)
            drive_req(1'b1, 1'b0, (i % 3 == 0) ? 48'h0 : 48'h1000, 2'h3, 64'(i + 1));
        n_vec++;
        if (err_ovf !== 1'b1 || ld_cnt !== ld_before + 32'd16) begin
            n_err++;
            $display("FAIL ovf_flags: got ovf=%b ld_delta=%0d want ovf=1 ld_delta=16",
                     err_ovf, ld_cnt - ld_before);
        end
        mc_rsp_stall = 1'b0;
        wait_drain();
        n_vec++;
        if (rcv_q.size() != 16) begin
            n_err++;
            $display("FAIL ovf_count: got %0d want 16", rcv_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rcv_q.size()) ? rcv_q[i] : '0;
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL ovf_rsp[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_protocol();
        rsp_t got;
        n_vec++;
        if (err_proto !== 1'b0) begin
            n_err++;
            $display("FAIL proto_before: got %b want 0", err_proto);
        end
        drive_req(1'b1, 1'b0, 48'h1004, 2'h2, 64'h1234);
        wait_drain();
        got = (rcv_q.size() > 0) ? rcv_q[0] : '0;
        n_vec++;
        if (rcv_q.size() != 1 || got !== {32'h1234, mdl_mem[512]}) begin
            n_err++;
            $display("FAIL proto_data: got %h want %h", got, {32'h1234, mdl_mem[512]});
        end
        n_vec++;
        if (err_proto !== 1'b1) begin
            n_err++;
            $display("FAIL proto_flag: got %b want 1", err_proto);
        end
        clear_q();
    endtask

    task automatic test_random();
        rsp_t        got;
        logic [47:0] va;
        logic        ld;
        logic        st;
        for (int i = 0; i < 32; i++) begin
            va = {16'($urandom), 32'($urandom)};
            va[12:3] = 10'(i);
            va[2:0] = 3'h0;
            drive_req(1'b0, 1'b1, va, 2'h3, {32'($urandom), 32'($urandom)});
        end
        for (int n = 0; n < 400; n++) begin
            va = {16'($urandom), 32'($urandom)};
            va[12:3] = 10'($urandom_range(0, 31));
            va[2:0] = 3'h0;
            ld = ($urandom_range(0, 99) < 55);
            st = ($urandom_range(0, 99) < 30);
            mc_rsp_stall = ($urandom_range(0, 99) < 35);
            drive_req(ld, st, va, 2'h3, {32'($urandom), 32'($urandom)});
        end
        mc_rsp_stall = 1'b0;
        wait_drain();
        n_vec++;
        if (rcv_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d want %0d", rcv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rcv_q.size()) ? rcv_q[i] : '0;
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_rsp[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        n_vec++;
        if (ld_cnt !== mdl_ld || st_cnt !== mdl_st || err_ovf !== mdl_ovf || err_proto !== mdl_proto) begin
            n_err++;
            $display("FAIL rand_status: got ld=%0d st=%0d ovf=%b proto=%b want ld=%0d st=%0d ovf=%b proto=%b",
                     ld_cnt, st_cnt, err_ovf, err_proto, mdl_ld, mdl_st, mdl_ovf, mdl_proto);
        end
        clear_q();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++)
            drive_req(1'b1, 1'b0, 48'h1000, 2'h3, 64'(200 + i));
        cycle();
        reset = 1'b1;
        clear_q();
        mdl_ld = 0;
        mdl_st = 0;
        mdl_ovf = 1'b0;
        mdl_proto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if ({mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push, mc_rsp_rdctl, mc_rsp_data,
                 ld_cnt, st_cnt, err_ovf, err_proto} !== '0) begin
                n_err++;
                $display("FAIL midflight_reset_outputs[%0d]: got push=%b ld_cnt=%0d proto=%b want all zero",
                         i, mc_rsp_push, ld_cnt, err_proto);
            end
        end
        reset = 1'b0;
        repeat (12) cycle();
        n_vec++;
        if (rcv_q.size() != 0 || ld_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL midflight_no_push: got %0d pushes ld_cnt=%0d want 0 0", rcv_q.size(), ld_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_store_readback();
        test_wrap();
        test_wr_stall();
        test_back_to_back();
        test_back_pressure();
        test_overflow();
        test_protocol();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
